uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_arbiter_if.sv | 31 +++
 rtl/rr_select.sv | 34 +++
 rtl/uart_tx.sv | 93 +++++++++
 rtl/uart_tx_arbiter.sv | 111 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 288 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ---- uart_pkg : shared arbiter state encodings and default sizing (rev 1.0) ----
package uart_pkg;

  localparam int c_DEF_NUM_REQ      = 4;
  localparam int c_DEF_BUSY_TIMEOUT = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ---- uart_tx_arbiter_if : requester / uart_tx handshake bundle (rev 1.0) ----
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = c_DEF_NUM_REQ
) ();

  logic [NUM_REQ-1:0]         req_valid;
  logic [8*NUM_REQ-1:0]       req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       tx_start;
  logic [7:0]                 tx_byte;
  logic                       tx_busy;
  logic [$clog2(NUM_REQ)-1:0] grant_id;
  logic                       arb_busy;
  logic                       timeout_err;

  // master is the arbiter; slave is the requester/uart side
  modport master (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_start, tx_byte, grant_id, arb_busy, timeout_err
  );

  modport slave (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_start, tx_byte, grant_id, arb_busy, timeout_err
  );

endinterface
`default_nettype wire

// File: rtl/rr_select.sv
`default_nettype none
// ---- rr_select : combinational round-robin winner search after last_grant (rev 1.0) ----
module rr_select #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_last,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_found
);

  localparam int c_IW = $clog2(NUM_REQ);

  int w_best;
  int w_dist;

  // distance 0 is the slot right after i_last; the nearest active requester wins
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_best  = NUM_REQ;
    w_dist  = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_dist = (j + NUM_REQ - 1 - int'(i_last)) % NUM_REQ;
      if (i_req[j] && (w_dist < w_best)) begin
        w_best  = w_dist;
        o_idx   = c_IW'(j);
        o_found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ---- uart_tx : 8N1 serialiser with a one-cycle cleanup after busy falls (rev 1.0) ----
module uart_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_tx,
  output logic       o_busy
);

  localparam int              c_CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    U_IDLE  = 3'd0,
    U_START = 3'd1,
    U_DATA  = 3'd2,
    U_STOP  = 3'd3,
    U_CLEAN = 3'd4
  } tx_state_t;

  tx_state_t       r_state;
  tx_state_t       w_next;
  logic [c_CW-1:0] r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_tx;
  logic            r_busy;
  logic            w_bit_end;
  logic            w_in_frame;

  assign w_bit_end  = (r_cnt == c_CNT_LAST);
  assign w_in_frame = (r_state == U_START) || (r_state == U_DATA) || (r_state == U_STOP);
  assign o_tx       = r_tx;
  assign o_busy     = r_busy;

  always_ff @(posedge clk) begin
    if (rst) r_state <= U_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      U_IDLE:  if (i_start)                      w_next = U_START;
      U_START: if (w_bit_end)                    w_next = U_DATA;
      U_DATA:  if (w_bit_end && r_bit == 3'd7)   w_next = U_STOP;
      U_STOP:  if (w_bit_end)                    w_next = U_CLEAN;
      U_CLEAN:                                   w_next = U_IDLE;
      default:                                   w_next = U_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_cnt <= (w_in_frame && !w_bit_end) ? r_cnt + 1'b1 : '0;
      case (r_state)
        U_IDLE: if (i_start) begin
          r_shift <= i_byte;
          r_tx    <= 1'b0;
          r_busy  <= 1'b1;
        end
        U_START: if (w_bit_end) begin
          r_tx  <= r_shift[0];
          r_bit <= '0;
        end
        U_DATA: if (w_bit_end) begin
          if (r_bit == 3'd7) begin
            r_tx <= 1'b1;
          end else begin
            r_tx    <= r_shift[1];
            r_shift <= r_shift >> 1;
            r_bit   <= r_bit + 1'b1;
          end
        end
        // busy drops at the end of the stop bit; CLEAN follows before IDLE
        U_STOP: if (w_bit_end) r_busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ---- uart_tx_arbiter : round-robin front end sharing one uart_tx among NUM_REQ requesters (rev 1.0) ----
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = c_DEF_NUM_REQ,
  parameter int BUSY_TIMEOUT = c_DEF_BUSY_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arbiter_if.master  bus
);

  localparam int              c_IW      = $clog2(NUM_REQ);
  localparam int              c_TW      = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(BUSY_TIMEOUT - 1);

  arb_state_t         r_state;
  arb_state_t         w_next;
  logic [c_IW-1:0]    r_last_grant;
  logic [c_IW-1:0]    r_grant_id;
  logic [c_IW-1:0]    w_win_idx;
  logic               w_found;
  logic [NUM_REQ-1:0] w_win_onehot;
  logic [7:0]         w_win_byte;
  logic [c_TW-1:0]    r_to_cnt;
  logic               r_tx_start;
  logic [7:0]         r_tx_byte;
  logic [NUM_REQ-1:0] r_req_ready;
  logic               r_timeout_err;
  logic               w_grant;
  logic               w_timeout;

  rr_select #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_select (
    .i_req   (bus.req_valid),
    .i_last  (r_last_grant),
    .o_idx   (w_win_idx),
    .o_found (w_found)
  );

  always_comb begin
    w_win_onehot = '0;
    w_win_byte   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_win_idx == c_IW'(j)) begin
        w_win_onehot[j] = 1'b1;
        w_win_byte      = bus.req_data[8*j +: 8];
      end
    end
  end

  assign w_grant   = (r_state == ST_IDLE) && w_found;
  assign w_timeout = (r_state == ST_WAIT_BUSY) && !bus.tx_busy && (r_to_cnt == c_TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (w_found) w_next = ST_LAUNCH;
      ST_LAUNCH:    w_next = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (bus.tx_busy)    w_next = ST_WAIT_DONE;
        else if (w_timeout) w_next = ST_IDLE;
      end
      // the IDLE cycle after busy falls covers uart_tx's cleanup cycle
      ST_WAIT_DONE: if (!bus.tx_busy) w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_start    <= 1'b0;
      r_tx_byte     <= '0;
      r_req_ready   <= '0;
      r_grant_id    <= '0;
      r_last_grant  <= c_IW'(NUM_REQ - 1);
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_tx_start  <= w_grant;
      r_req_ready <= w_grant ? w_win_onehot : '0;
      if (w_grant) begin
        r_tx_byte    <= w_win_byte;
        r_grant_id   <= w_win_idx;
        r_last_grant <= w_win_idx;
      end
      if (r_state == ST_LAUNCH)
        r_to_cnt <= '0;
      else if ((r_state == ST_WAIT_BUSY) && !bus.tx_busy && !w_timeout)
        r_to_cnt <= r_to_cnt + 1'b1;
      if (w_timeout)
        r_timeout_err <= 1'b1;
    end
  end

  assign bus.tx_start    = r_tx_start;
  assign bus.tx_byte     = r_tx_byte;
  assign bus.req_ready   = r_req_ready;
  assign bus.grant_id    = r_grant_id;
  assign bus.timeout_err = r_timeout_err;
  assign bus.arb_busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ---- tb_uart_tx_arbiter : directed self-checking bench for uart_tx_arbiter + uart_tx (rev 1.0) ----
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int BUSY_TIMEOUT = 4;
  localparam int CPB          = 4;
  localparam int CYC_LIMIT    = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) ifc ();

  // dead-uart model: tx_busy never rises while selected
  logic use_model  = 1'b0;
  logic model_busy = 1'b0;
  logic w_uart_start;
  logic w_uart_busy;
  logic w_line;

  assign w_uart_start = ifc.tx_start & ~use_model;
  assign ifc.tx_busy  = use_model ? model_busy : w_uart_busy;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  uart_tx #(
    .CLKS_PER_BIT (CPB)
  ) u_uart (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_uart_start),
    .i_byte  (ifc.tx_byte),
    .o_tx    (w_line),
    .o_busy  (w_uart_busy)
  );

  int n_cmp     = 0;
  int n_bad     = 0;
  int n_overlap = 0;
  int n_starts  = 0;
  int n_readys  = 0;

  always @(negedge clk) begin
    if (ifc.tx_start && ifc.tx_busy) n_overlap++;
    if (ifc.tx_start)                n_starts++;
    if (ifc.req_ready != '0)         n_readys++;
  end

  // serial line receiver: mid-bit sampling, LSB first
  logic [7:0] rx_q[$];
  logic [7:0] rx_byte;
  always begin
    @(negedge w_line);
    if (!rst) begin
      repeat (CPB / 2) @(posedge clk);
      #1;
      if (w_line == 1'b0) begin
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(posedge clk);
          #1;
          rx_byte[k] = w_line;
        end
        repeat (CPB) @(posedge clk);
        #1;
        if (w_line == 1'b1) rx_q.push_back(rx_byte);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no event within %0d cycles", name, CYC_LIMIT);
  endtask

  task automatic wait_ready(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < CYC_LIMIT; i++) begin
      @(negedge clk);
      if (ifc.req_ready != '0) begin ok = 1'b1; break; end
    end
    if (!ok) expire(name);
  endtask

  task automatic wait_busy(input string name, input logic level, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < CYC_LIMIT; i++) begin
      @(negedge clk);
      if (ifc.tx_busy === level) begin ok = 1'b1; break; end
    end
    if (!ok) expire(name);
  endtask

  task automatic wait_rx(input string name, input logic [7:0] exp);
    for (int i = 0; i < CYC_LIMIT; i++) begin
      if (rx_q.size() > 0) break;
      @(negedge clk);
    end
    if (rx_q.size() == 0) expire(name);
    else                  check(name, rx_q.pop_front(), exp);
  endtask

  typedef struct {
    bit         load;
    logic [3:0] valid;
    logic [31:0] data;
    logic [3:0] drop;
    logic [3:0] exp_ready;
    logic [7:0] exp_byte;
    logic [1:0] exp_grant;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int gap;
    bit seen;

    //        load valid  data          drop   ready  byte   grant
    vecs[0] = '{1'b1, 4'hF, 32'h43322110, 4'h0, 4'h1, 8'h10, 2'd0};
    vecs[1] = '{1'b0, 4'hF, 32'h43322110, 4'h0, 4'h2, 8'h21, 2'd1};
    vecs[2] = '{1'b0, 4'hF, 32'h43322110, 4'h0, 4'h4, 8'h32, 2'd2};
    vecs[3] = '{1'b0, 4'hF, 32'h43322110, 4'h0, 4'h8, 8'h43, 2'd3};
    vecs[4] = '{1'b0, 4'hF, 32'h43322110, 4'hF, 4'h1, 8'h10, 2'd0};
    vecs[5] = '{1'b1, 4'h4, 32'h00A50000, 4'h4, 4'h4, 8'hA5, 2'd2};
    vecs[6] = '{1'b1, 4'h9, 32'h5C000077, 4'h8, 4'h8, 8'h5C, 2'd3};
    vecs[7] = '{1'b0, 4'h0, 32'h00000000, 4'h1, 4'h1, 8'h77, 2'd0};

    ifc.req_valid = '0;
    ifc.req_data  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset tx_start",    ifc.tx_start,    0);
    check("reset tx_byte",     ifc.tx_byte,     0);
    check("reset req_ready",   ifc.req_ready,   0);
    check("reset grant_id",    ifc.grant_id,    0);
    check("reset timeout_err", ifc.timeout_err, 0);
    check("reset arb_busy",    ifc.arb_busy,    0);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle quiet", {ifc.arb_busy, ifc.tx_start, ifc.req_ready}, 0);
    end

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].load) begin
        ifc.req_valid = vecs[v].valid;
        ifc.req_data  = vecs[v].data;
      end
      wait_ready($sformatf("vec%0d wait ready", v), ok);
      if (ok) begin
        check($sformatf("vec%0d req_ready", v), ifc.req_ready, vecs[v].exp_ready);
        check($sformatf("vec%0d grant_id", v),  ifc.grant_id,  vecs[v].exp_grant);
        check($sformatf("vec%0d tx_byte", v),   ifc.tx_byte,   vecs[v].exp_byte);
        check($sformatf("vec%0d tx_start", v),  ifc.tx_start,  1);
        check($sformatf("vec%0d arb_busy", v),  ifc.arb_busy,  1);
        ifc.req_valid = ifc.req_valid & ~vecs[v].drop;
        @(negedge clk);
        check($sformatf("vec%0d ready pulse", v), ifc.req_ready, 0);
        check($sformatf("vec%0d start pulse", v), ifc.tx_start,  0);
        wait_rx($sformatf("vec%0d line byte", v), vecs[v].exp_byte);
      end
    end

    // back-to-back frames from requester 1
    rx_q.delete();
    ifc.req_data  = 32'h00006600;
    ifc.req_valid = 4'b0010;
    wait_ready("b2b first ready", ok);
    for (int f = 0; f < 3 && ok; f++) begin
      check("b2b req_ready", ifc.req_ready, 4'b0010);
      check("b2b grant_id",  ifc.grant_id,  1);
      check("b2b tx_byte",   ifc.tx_byte,   8'h66);
      wait_busy("b2b busy rise", 1'b1, ok);
      if (ok) wait_busy("b2b busy fall", 1'b0, ok);
      if (ok && f == 2) ifc.req_valid = '0;
      if (ok && f < 2) begin
        gap  = 0;
        seen = 1'b0;
        for (int i = 0; i < CYC_LIMIT; i++) begin
          @(negedge clk);
          gap++;
          if (ifc.tx_start) begin seen = 1'b1; break; end
        end
        check("b2b idle gap >= 2", {31'd0, (seen && gap >= 2)}, 1);
        ok = seen;
      end
    end
    ifc.req_valid = '0;
    repeat (4) @(negedge clk);
    check("b2b line count", rx_q.size(), 3);
    while (rx_q.size() > 0) check("b2b line byte", rx_q.pop_front(), 8'h66);

    // busy never rises
    use_model     = 1'b1;
    ifc.req_data  = 32'h0000003C;
    ifc.req_valid = 4'b0001;
    wait_ready("to wait ready", ok);
    if (ok) begin
      check("to grant_id", ifc.grant_id, 0);
      ifc.req_valid = '0;
      for (int k = 1; k <= BUSY_TIMEOUT + 1; k++) begin
        @(negedge clk);
        if (k == BUSY_TIMEOUT) begin
          check("to err before limit",      ifc.timeout_err, 0);
          check("to arb_busy before limit", ifc.arb_busy,    1);
        end
        if (k == BUSY_TIMEOUT + 1) begin
          check("to err at limit",      ifc.timeout_err, 1);
          check("to arb_busy at limit", ifc.arb_busy,    0);
        end
      end
    end
    use_model     = 1'b0;
    ifc.req_data  = 32'hE7000000;
    ifc.req_valid = 4'b1000;
    wait_ready("post-to wait ready", ok);
    if (ok) begin
      check("post-to grant_id",  ifc.grant_id,    3);
      check("post-to tx_byte",   ifc.tx_byte,     8'hE7);
      check("post-to err stays", ifc.timeout_err, 1);
      ifc.req_valid = '0;
      wait_rx("post-to line byte", 8'hE7);
    end

    // reset in WAIT_DONE with requesters 2 and 3 pending
    ifc.req_data  = 32'h99440000;
    ifc.req_valid = 4'b0100;
    wait_ready("rst pre ready", ok);
    if (ok) begin
      check("rst pre grant_id", ifc.grant_id, 2);
      ifc.req_valid = 4'b1100;
      wait_busy("rst busy rise", 1'b1, ok);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid rst tx_start",    ifc.tx_start,    0);
      check("mid rst tx_byte",     ifc.tx_byte,     0);
      check("mid rst req_ready",   ifc.req_ready,   0);
      check("mid rst grant_id",    ifc.grant_id,    0);
      check("mid rst timeout_err", ifc.timeout_err, 0);
      check("mid rst arb_busy",    ifc.arb_busy,    0);
      check("mid rst uart busy",   ifc.tx_busy,     0);
      rst = 1'b0;
      wait_ready("post-rst ready", ok);
      if (ok) begin
        check("post-rst req_ready", ifc.req_ready, 4'b0100);
        check("post-rst grant_id",  ifc.grant_id,  2);
        check("post-rst tx_byte",   ifc.tx_byte,   8'h44);
      end
      ifc.req_valid = '0;
    end

    repeat (2) @(negedge clk);
    check("no start while busy",  n_overlap, 0);
    check("one start per accept", n_starts,  n_readys);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
